// File: rtl/sa_wresp_channel_if.sv
// Write-response channel bundle for one slave port. It carries the AW
// order-tracking strobes, the slave B channel, and the per-master dispatcher
// B channels.
interface sa_wresp_channel_if #(
   parameter int MST_AMT         = 2,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int TRANS_WR_RESP_W = 2,
   parameter int MST_ID_W        = $clog2(MST_AMT)
);
   // AW order tracking
   logic [MST_ID_W-1:0]                sa_AW_mst_id_i;
   logic                               sa_AW_shift_en_i;
   logic                               sa_AW_stall_o;
   // slave-side B channel
   logic [TRANS_MST_ID_W-1:0]          s_BID_i;
   logic [TRANS_WR_RESP_W-1:0]         s_BRESP_i;
   logic                               s_BVALID_i;
   logic                               s_BREADY_o;
   // dispatcher-side B channels, one slice per master
   logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_BID_o;
   logic [TRANS_WR_RESP_W*MST_AMT-1:0] dsp_BRESP_o;
   logic [MST_AMT-1:0]                 dsp_BVALID_o;
   logic [MST_AMT-1:0]                 dsp_BREADY_i;
   // protocol error flag
   logic                               unexp_resp_o;

   // The channel block itself
   modport slave (
      input  sa_AW_mst_id_i, sa_AW_shift_en_i, s_BID_i, s_BRESP_i, s_BVALID_i,
             dsp_BREADY_i,
      output sa_AW_stall_o, s_BREADY_o, dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o,
             unexp_resp_o
   );

   // Whatever drives the channel (arbiter, slave, dispatchers)
   modport master (
      output sa_AW_mst_id_i, sa_AW_shift_en_i, s_BID_i, s_BRESP_i, s_BVALID_i,
             dsp_BREADY_i,
      input  sa_AW_stall_o, s_BREADY_o, dsp_BID_o, dsp_BRESP_o, dsp_BVALID_o,
             unexp_resp_o
   );
endinterface

// File: rtl/sa_wresp_channel.sv
// Slave-port write-response router. It records which master each granted AW
// came from, in order. It then steers each slave B response to that master
// through a one-entry output register.
module sa_wresp_channel #(
   parameter int MST_AMT         = 2,
   parameter int OUTSTANDING_AMT = 8,
   parameter int TRANS_MST_ID_W  = 5,
   parameter int TRANS_WR_RESP_W = 2,
   parameter int MST_ID_W        = $clog2(MST_AMT)
) (
   input  logic                 ACLK_i,
   input  logic                 ARESET_i,
   sa_wresp_channel_if.slave    bus
);
   localparam int PTR_W = $clog2(OUTSTANDING_AMT);
   localparam int CNT_W = PTR_W + 1;

   // Master-order FIFO. It is shallow, so the head is read combinationally.
   logic [MST_ID_W-1:0] ord_mem [OUTSTANDING_AMT];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                ord_full;
   logic                ord_empty;
   logic [MST_ID_W-1:0] ord_head;

   // Output register
   logic                       out_valid;
   logic [MST_ID_W-1:0]        out_mst;
   logic [TRANS_MST_ID_W-1:0]  out_bid;
   logic [TRANS_WR_RESP_W-1:0] out_bresp;
   logic                       unexp_resp;

   logic s_bready;
   logic take;    // slave handshake: capture response, pop order entry
   logic drain;   // dispatcher accepts the held response
   logic push;

   assign ord_full  = (count == CNT_W'(OUTSTANDING_AMT));
   assign ord_empty = (count == '0);
   assign ord_head  = ord_mem[rd_ptr];

   assign drain    = out_valid & bus.dsp_BREADY_i[out_mst];
   // The slave is accepted only when we know where its response goes and the
   // register is free or emptying this cycle. There is no bypass from push.
   assign s_bready = ~ord_empty & (~out_valid | bus.dsp_BREADY_i[out_mst]);
   assign take     = bus.s_BVALID_i & s_bready;
   // A pop in the same cycle makes room, so a push into a full FIFO is kept.
   assign push     = bus.sa_AW_shift_en_i & (~ord_full | take);

   // Order storage write. It has no reset; the pointers define the contents.
   always_ff @(posedge ACLK_i) begin
      if (push) ord_mem[wr_ptr] <= bus.sa_AW_mst_id_i;
   end

   // FIFO pointers and occupancy. The pointers wrap naturally (power-of-two depth).
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (take) rd_ptr <= rd_ptr + 1'b1;
         case ({push, take})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Output register: capture has priority and gives back-to-back throughput.
   // Otherwise, a drain empties the register and everything else holds.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         out_valid <= 1'b0;
         out_mst   <= '0;
         out_bid   <= '0;
         out_bresp <= '0;
      end else if (take) begin
         out_valid <= 1'b1;
         out_mst   <= ord_head;
         out_bid   <= bus.s_BID_i;
         out_bresp <= bus.s_BRESP_i;
      end else if (drain) begin
         out_valid <= 1'b0;
      end
   end

   // Sticky flag: the slave raised BVALID with nothing outstanding.
   always_ff @(posedge ACLK_i or posedge ARESET_i) begin
      if (ARESET_i) begin
         unexp_resp <= 1'b0;
      end else if (bus.s_BVALID_i & ord_empty & ~out_valid) begin
         unexp_resp <= 1'b1;
      end
   end

   // Per-master fan-out of the output register
   logic [MST_AMT-1:0]                 dsp_bvalid;
   logic [TRANS_MST_ID_W*MST_AMT-1:0]  dsp_bid;
   logic [TRANS_WR_RESP_W*MST_AMT-1:0] dsp_bresp;

   genvar gi;
   generate
      for (gi = 0; gi < MST_AMT; gi++) begin : g_dsp
         logic sel;
         assign sel = (out_mst == MST_ID_W'(gi));
         assign dsp_bvalid[gi] = out_valid & sel;
         assign dsp_bid[TRANS_MST_ID_W*(gi+1)-1 -: TRANS_MST_ID_W] =
            sel ? out_bid : '0;
         assign dsp_bresp[TRANS_WR_RESP_W*(gi+1)-1 -: TRANS_WR_RESP_W] =
            sel ? out_bresp : '0;
      end
   endgenerate

   assign bus.dsp_BVALID_o  = dsp_bvalid;
   assign bus.dsp_BID_o     = dsp_bid;
   assign bus.dsp_BRESP_o   = dsp_bresp;
   assign bus.s_BREADY_o    = s_bready;
   assign bus.sa_AW_stall_o = ord_full;
   assign bus.unexp_resp_o  = unexp_resp;

endmodule

// File: tb/tb_sa_wresp_channel.sv
// Directed bench for sa_wresp_channel with default parameters
// (2 masters, depth 8, 5-bit BID, 2-bit BRESP).
module tb_sa_wresp_channel;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   sa_wresp_channel_if #(.MST_AMT(2), .TRANS_MST_ID_W(5), .TRANS_WR_RESP_W(2)) bus ();

   sa_wresp_channel #(
      .MST_AMT(2), .OUTSTANDING_AMT(8), .TRANS_MST_ID_W(5), .TRANS_WR_RESP_W(2)
   ) dut (
      .ACLK_i  (clk),
      .ARESET_i(rst),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Advance one clock. Inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bvalid"}, 32'(bus.dsp_BVALID_o), 0);
      chk({tag, "_bid"},    32'(bus.dsp_BID_o),    0);
      chk({tag, "_bresp"},  32'(bus.dsp_BRESP_o),  0);
      chk({tag, "_sready"}, 32'(bus.s_BREADY_o),   0);
      chk({tag, "_stall"},  32'(bus.sa_AW_stall_o), 0);
      chk({tag, "_unexp"},  32'(bus.unexp_resp_o), 0);
   endtask

   initial begin
      bus.sa_AW_mst_id_i   = '0;
      bus.sa_AW_shift_en_i = 1'b0;
      bus.s_BID_i          = '0;
      bus.s_BRESP_i        = '0;
      bus.s_BVALID_i       = 1'b0;
      bus.dsp_BREADY_i     = 2'b11;

      // ---- reset state
      repeat (2) tick();
      chk_idle("in_reset");
      rst = 1'b0;
      tick();
      chk_idle("after_reset");

      // ---- single response to master 1
      bus.sa_AW_mst_id_i = 1'b1; bus.sa_AW_shift_en_i = 1'b1;
      #1 chk("no_bypass_sready", 32'(bus.s_BREADY_o), 0);
      tick();
      bus.sa_AW_shift_en_i = 1'b0;
      chk("one_sready", 32'(bus.s_BREADY_o), 1);
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd5; bus.s_BRESP_i = 2'd0;
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("one_bvalid", 32'(bus.dsp_BVALID_o), 2);
      chk("one_bid",    32'(bus.dsp_BID_o),    32'd5 << 5);
      chk("one_empty_sready", 32'(bus.s_BREADY_o), 0);
      tick();
      chk("one_drained", 32'(bus.dsp_BVALID_o), 0);

      // ---- back-to-back responses for masters 0, 1, 0
      bus.sa_AW_shift_en_i = 1'b1;
      bus.sa_AW_mst_id_i = 1'b0; tick();
      bus.sa_AW_mst_id_i = 1'b1; tick();
      bus.sa_AW_mst_id_i = 1'b0; tick();
      bus.sa_AW_shift_en_i = 1'b0;
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd3; bus.s_BRESP_i = 2'd1;
      tick();
      chk("b2b0_bvalid", 32'(bus.dsp_BVALID_o), 1);
      chk("b2b0_bid",    32'(bus.dsp_BID_o),    3);
      chk("b2b0_bresp",  32'(bus.dsp_BRESP_o),  1);
      chk("b2b0_sready", 32'(bus.s_BREADY_o),   1);
      bus.s_BID_i = 5'd4; bus.s_BRESP_i = 2'd2;
      tick();
      chk("b2b1_bvalid", 32'(bus.dsp_BVALID_o), 2);
      chk("b2b1_bid",    32'(bus.dsp_BID_o),    32'd4 << 5);
      chk("b2b1_bresp",  32'(bus.dsp_BRESP_o),  32'd2 << 2);
      chk("b2b1_sready", 32'(bus.s_BREADY_o),   1);
      bus.s_BID_i = 5'd7; bus.s_BRESP_i = 2'd3;
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("b2b2_bvalid", 32'(bus.dsp_BVALID_o), 1);
      chk("b2b2_bid",    32'(bus.dsp_BID_o),    7);
      chk("b2b2_bresp",  32'(bus.dsp_BRESP_o),  3);
      tick();
      chk("b2b_drained", 32'(bus.dsp_BVALID_o), 0);

      // ---- fill the FIFO (order 0,1,0,1,0,1,0,1), then try a 9th push
      bus.sa_AW_shift_en_i = 1'b1;
      for (int k = 0; k < 8; k++) begin
         bus.sa_AW_mst_id_i = 1'(k % 2);
         tick();
      end
      chk("full_stall", 32'(bus.sa_AW_stall_o), 1);
      bus.sa_AW_mst_id_i = 1'b1;
      tick();
      bus.sa_AW_shift_en_i = 1'b0;
      chk("ninth_stall", 32'(bus.sa_AW_stall_o), 1);
      // one response drains -> no longer full
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd0; bus.s_BRESP_i = 2'd0;
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("pop_bvalid", 32'(bus.dsp_BVALID_o), 1);
      chk("pop_stall",  32'(bus.sa_AW_stall_o), 0);
      // refill to full with master 0 -> order 1,0,1,0,1,0,1,0
      bus.sa_AW_shift_en_i = 1'b1; bus.sa_AW_mst_id_i = 1'b0;
      tick();
      chk("refull_stall", 32'(bus.sa_AW_stall_o), 1);
      // push and pop together while full -> count stays 8, order 0,1,0,1,0,1,0,1
      bus.sa_AW_mst_id_i = 1'b1;
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd1;
      tick();
      bus.sa_AW_shift_en_i = 1'b0;
      chk("pushpop_bvalid", 32'(bus.dsp_BVALID_o), 2);
      chk("pushpop_stall",  32'(bus.sa_AW_stall_o), 1);
      for (int k = 0; k < 8; k++) begin
         bus.s_BID_i = 5'(k + 2);
         tick();
         chk($sformatf("drain%0d_bvalid", k), 32'(bus.dsp_BVALID_o), (k % 2) ? 2 : 1);
      end
      bus.s_BVALID_i = 1'b0;
      #1 chk("drain_empty_sready", 32'(bus.s_BREADY_o), 0);
      tick();

      // ---- backpressure from master 0
      bus.sa_AW_shift_en_i = 1'b1;
      bus.sa_AW_mst_id_i = 1'b0; tick();
      bus.sa_AW_mst_id_i = 1'b1; tick();
      bus.sa_AW_shift_en_i = 1'b0;
      bus.dsp_BREADY_i = 2'b10;
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd9; bus.s_BRESP_i = 2'd2;
      tick();
      bus.s_BID_i = 5'd10; bus.s_BRESP_i = 2'd1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("hold%0d_sready", k), 32'(bus.s_BREADY_o), 0);
         chk($sformatf("hold%0d_bvalid", k), 32'(bus.dsp_BVALID_o), 1);
         chk($sformatf("hold%0d_bid", k),    32'(bus.dsp_BID_o), 9);
         chk($sformatf("hold%0d_bresp", k),  32'(bus.dsp_BRESP_o), 2);
         tick();
      end
      bus.dsp_BREADY_i = 2'b11;
      #1 chk("release_sready", 32'(bus.s_BREADY_o), 1);
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("release_bvalid", 32'(bus.dsp_BVALID_o), 2);
      chk("release_bid",    32'(bus.dsp_BID_o), 32'd10 << 5);
      tick();
      chk("release_drained", 32'(bus.dsp_BVALID_o), 0);

      // ---- unexpected response
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd2;
      #1 chk("unexp_sready", 32'(bus.s_BREADY_o), 0);
      chk("unexp_before", 32'(bus.unexp_resp_o), 0);
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("unexp_set", 32'(bus.unexp_resp_o), 1);
      repeat (3) tick();
      chk("unexp_sticky", 32'(bus.unexp_resp_o), 1);

      // ---- reset mid-transfer: one held response plus 3 pending entries
      bus.sa_AW_shift_en_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bus.sa_AW_mst_id_i = 1'(k % 2);
         tick();
      end
      bus.sa_AW_shift_en_i = 1'b0;
      bus.dsp_BREADY_i = 2'b00;
      bus.s_BVALID_i = 1'b1; bus.s_BID_i = 5'd6; bus.s_BRESP_i = 2'd3;
      tick();
      bus.s_BVALID_i = 1'b0;
      chk("pre_rst_bvalid", 32'(bus.dsp_BVALID_o), 1);
      #2 rst = 1'b1;
      #1 chk_idle("async_rst");
      tick();
      rst = 1'b0;
      bus.dsp_BREADY_i = 2'b11;
      tick();
      chk_idle("post_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
